// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer around the Sobel core: loads a frame into BRAM0,
// kicks the core, then streams BRAM1 out with valid/ready backpressure.
module sobel_frame_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100,
    parameter int MAX_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int RUN_OUT_CNT  = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_mode_run,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  b0_ce0,
    output logic                  b0_we0,
    output logic [ADDR_WIDTH-1:0] b0_addr0,
    output logic [DATA_WIDTH-1:0] b0_d0,
    output logic                  o_core_en,
    output logic [ADDR_WIDTH-1:0] o_core_num_cnt,
    output logic                  o_core_run,
    input  logic                  i_core_idle,
    input  logic                  i_core_done,
    output logic                  b1_ce0,
    output logic [ADDR_WIDTH-1:0] b1_addr0,
    input  logic [DATA_WIDTH-1:0] b1_q0,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  o_busy,
    output logic                  o_err_len
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] RUN_TOTAL = ADDR_WIDTH'(RUN_OUT_CNT);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic [ADDR_WIDTH-1:0] out_total;
    logic                  run_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [1:0]            occ_next;
    logic                  rd_pend;
    logic                  s_hs;
    logic                  frame_end;
    logic                  trunc;
    logic                  issue;
    logic                  pop;

    assign s_ready = rst_n &&
                     ((state == S_LOAD) ||
                      (state == S_IDLE && i_core_idle));
    assign s_hs      = s_valid && s_ready;
    assign wr_addr   = (state == S_IDLE) ? '0 : wr_cnt;
    assign frame_end = s_hs && (s_last || wr_addr == LAST_ADDR);
    assign trunc     = frame_end && !s_last;

    assign out_total = run_q ? RUN_TOTAL : num_q;
    assign m_valid   = (state == S_DRAIN) && (fifo_cnt != 2'd0);
    assign pop       = m_valid && m_ready;
    // Occupancy counted net of this cycle's pop so a full-rate stream never bubbles.
    assign occ_next  = fifo_cnt - {1'b0, pop} + {1'b0, rd_pend};
    assign issue     = (state == S_DRAIN) && (rd_addr != out_total) &&
                       (occ_next < 2'd2);

    assign o_core_num_cnt = num_q;
    assign o_core_run     = run_q;
    assign o_err_len      = err_q;
    assign o_busy         = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (s_hs) state_nx = frame_end ? S_KICK : S_LOAD;
            S_LOAD:  if (frame_end) state_nx = S_KICK;
            S_KICK:  state_nx = S_WAIT;
            S_WAIT:  if (i_core_done) state_nx = S_DRAIN;
            S_DRAIN: if (pop && m_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-state outputs: BRAM0 write port, core kick, BRAM1 read port, stream data.
    always_comb begin
        b0_ce0    = s_hs;
        b0_we0    = s_hs;
        b0_addr0  = s_hs ? wr_addr : '0;
        b0_d0     = s_hs ? s_data : '0;
        o_core_en = (state == S_KICK);
        b1_ce0    = issue;
        b1_addr0  = issue ? rd_addr : '0;
        m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
        m_last    = m_valid && (out_idx == out_total - 1'b1);
    end

    // Input side: write counter, frame length, mode and truncation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            num_q  <= '0;
            run_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (s_hs) begin
            if (state == S_IDLE) begin
                run_q <= i_mode_run;
                err_q <= trunc;
            end else if (trunc) begin
                err_q <= 1'b1;
            end
            if (frame_end) begin
                wr_cnt <= wr_addr;
                num_q  <= wr_addr + 1'b1;
            end else begin
                wr_cnt <= wr_addr + 1'b1;
            end
        end
    end

    // Output side: read issue, in-flight tracking and 2-entry skid FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            out_idx     <= '0;
            rd_pend     <= 1'b0;
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (state == S_WAIT) begin
            rd_addr  <= '0;
            out_idx  <= '0;
            rd_pend  <= 1'b0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            rd_pend  <= issue;
            fifo_cnt <= occ_next;
            if (issue) rd_addr <= rd_addr + 1'b1;
            if (rd_pend) begin
                fifo_mem[wr_ptr] <= b1_q0;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_idx <= out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Bench for sobel_frame_scheduler: BRAM and core models, a frame table,
// a reset-in-WAIT sequence and randomized frames against a frame-level model.
module tb_sobel_frame_scheduler;

    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int MAXP = 16;
    localparam int RUNO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mode_run = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          b0_ce0, b0_we0;
    logic [AW-1:0] b0_addr0;
    logic [DW-1:0] b0_d0;
    logic          o_core_en;
    logic [AW-1:0] o_core_num_cnt;
    logic          o_core_run;
    logic          i_core_idle, i_core_done;
    logic          b1_ce0;
    logic [AW-1:0] b1_addr0;
    logic [DW-1:0] b1_q0 = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          o_busy, o_err_len;

    always #5 clk = ~clk;

    sobel_frame_scheduler #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_mode_run(i_mode_run),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .b0_ce0(b0_ce0), .b0_we0(b0_we0),
        .b0_addr0(b0_addr0), .b0_d0(b0_d0), .o_core_en(o_core_en),
        .o_core_num_cnt(o_core_num_cnt), .o_core_run(o_core_run),
        .i_core_idle(i_core_idle), .i_core_done(i_core_done),
        .b1_ce0(b1_ce0), .b1_addr0(b1_addr0), .b1_q0(b1_q0),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .o_busy(o_busy), .o_err_len(o_err_len)
    );

    logic any_out;
    assign any_out = s_ready | b0_ce0 | b0_we0 | (|b0_addr0) | (|b0_d0) |
                     o_core_en | (|o_core_num_cnt) | o_core_run | b1_ce0 |
                     (|b1_addr0) | m_valid | (|m_data) | m_last | o_busy |
                     o_err_len;

    // BRAM1 model: one-cycle read latency.
    logic [DW-1:0] bram1 [MAXP];
    always @(posedge clk) if (b1_ce0) b1_q0 <= bram1[b1_addr0[3:0]];

    // Core model: busy for core_lat cycles after a kick, then one done pulse.
    int   core_lat = 3;
    bit   stray = 1'b0;
    int   core_cnt = 0;
    logic core_done_r = 1'b0;
    logic core_idle_r = 1'b1;
    always @(posedge clk) begin
        core_done_r <= 1'b0;
        if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done_r <= 1'b1;
                core_idle_r <= 1'b1;
            end
        end else if (o_core_en) begin
            core_cnt    <= core_lat;
            core_idle_r <= 1'b0;
        end
    end
    assign i_core_idle = core_idle_r;
    assign i_core_done = core_done_r | (stray & o_core_en);

    // Output backpressure pattern, cycled every 4 clocks.
    bit [3:0] rdy_pat = 4'hF;
    initial begin : rdy_drv
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_pat[ph];
            ph = (ph + 1) % 4;
        end
    end

    // Monitor: cumulative records sampled on the falling edge.
    int            cyc = 0, en_cnt = 0, done_cyc = 0, mv_cyc = 0;
    int            rd_iss = 0, pops = 0, ovf_cnt = 0, hold_cnt = 0;
    logic [AW-1:0] num_seen = '0;
    logic          run_seen = 1'b0;
    bit            done_flag = 1'b0, mv_flag = 1'b0, addr0_flag = 1'b0;
    logic          err_after1 = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] od_q[$];
    bit            ol_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (b0_ce0 && b0_we0) begin
            wa_q.push_back(b0_addr0);
            wd_q.push_back(b0_d0);
        end
        addr0_flag <= b0_ce0 && b0_we0 && (b0_addr0 == '0);
        if (addr0_flag) err_after1 <= o_err_len;
        if (o_core_en) begin
            en_cnt    <= en_cnt + 1;
            num_seen  <= o_core_num_cnt;
            run_seen  <= o_core_run;
            done_flag <= 1'b0;
            mv_flag   <= 1'b0;
        end else begin
            if (core_done_r && !done_flag) begin
                done_flag <= 1'b1;
                done_cyc  <= cyc;
            end
            if (m_valid && !mv_flag) begin
                mv_flag <= 1'b1;
                mv_cyc  <= cyc;
            end
        end
        if (b1_ce0) rd_iss <= rd_iss + 1;
        if (m_valid && m_ready) begin
            pops <= pops + 1;
            od_q.push_back(m_data);
            ol_q.push_back(m_last);
        end
        if (b1_ce0 && (rd_iss + 1 - pops - int'(m_valid && m_ready)) > 2)
            ovf_cnt <= ovf_cnt + 1;
        if (prev_stall && !(m_valid && m_data == prev_data))
            hold_cnt <= hold_cnt + 1;
        prev_stall <= m_valid && !m_ready;
        prev_data  <= m_data;
    end

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string nm, input longint got, input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, exp);
    endtask

    typedef struct {
        bit       mode;
        int       len;
        bit       lst;
        bit [3:0] pat;
        int       lat;
        bit       stray;
        int       exp_num;
        bit       exp_err;
        int       exp_beats;
    } vec_t;

    // Frame-level reference: length cap, truncation flag and readout length.
    function automatic vec_t model(bit mode, int len, bit lst);
        vec_t v;
        v.mode      = mode;
        v.len       = len;
        v.lst       = lst;
        v.pat       = 4'hF;
        v.lat       = 1;
        v.stray     = 1'b0;
        v.exp_num   = (len < MAXP) ? len : MAXP;
        v.exp_err   = !(lst && len <= MAXP);
        v.exp_beats = mode ? RUNO : v.exp_num;
        return v;
    endfunction

    logic [DW-1:0] acc_q[$];

    task automatic drive_frame(input bit mode, input int len, input bit lst);
        int i;
        int waitc;
        i = 0;
        waitc = 0;
        acc_q.delete();
        while (i < len) begin
            @(posedge clk);
            #1;
            s_valid    = 1'b1;
            s_data     = DW'($urandom);
            s_last     = lst && (i == len - 1);
            i_mode_run = mode;
            @(negedge clk);
            if (s_ready) begin
                acc_q.push_back(s_data);
                i++;
            end else if (i > 0) begin
                break;
            end else begin
                waitc++;
                if (waitc > 300) begin
                    chk("s_ready_wait", 0, 1);
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int ob, eb, wb, rb, hb, ib, t, mis;
        for (int a = 0; a < MAXP; a++) bram1[a] = DW'($urandom);
        rdy_pat  = v.pat;
        core_lat = v.lat;
        stray    = v.stray;
        ob = od_q.size();
        eb = en_cnt;
        wb = wa_q.size();
        rb = ovf_cnt;
        hb = hold_cnt;
        ib = rd_iss;
        drive_frame(v.mode, v.len, v.lst);
        t = 0;
        while (o_busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ":done"}, o_busy, 0);
        chk({tag, ":en_pulses"}, en_cnt - eb, 1);
        chk({tag, ":num_cnt"}, num_seen, v.exp_num);
        chk({tag, ":run"}, run_seen, v.mode);
        chk({tag, ":err_len"}, o_err_len, v.exp_err);
        chk({tag, ":err_clr"}, err_after1, 0);
        chk({tag, ":writes"}, wa_q.size() - wb, v.exp_num);
        mis = 0;
        for (int k = 0; k < acc_q.size(); k++)
            if (wb + k >= wa_q.size()) mis++;
            else if (wa_q[wb+k] != AW'(k) || wd_q[wb+k] != acc_q[k]) mis++;
        chk({tag, ":bram0"}, mis, 0);
        chk({tag, ":beats"}, od_q.size() - ob, v.exp_beats);
        chk({tag, ":reads"}, rd_iss - ib, v.exp_beats);
        mis = 0;
        for (int k = 0; k < v.exp_beats; k++)
            if (ob + k >= od_q.size()) mis++;
            else if (od_q[ob+k] != bram1[k]) mis++;
        chk({tag, ":data"}, mis, 0);
        mis = 0;
        for (int k = 0; k < v.exp_beats; k++)
            if (ob + k >= ol_q.size()) mis++;
            else if (ol_q[ob+k] != (k == v.exp_beats - 1)) mis++;
        chk({tag, ":last"}, mis, 0);
        chk({tag, ":latency"}, mv_cyc - done_cyc, 3);
        chk({tag, ":outstanding"}, ovf_cnt - rb, 0);
        chk({tag, ":hold"}, hold_cnt - hb, 0);
    endtask

    vec_t tbl[10];
    vec_t rv;
    bit   md, ls;
    int   ln;

    initial begin
        tbl[0] = '{0, 16, 1, 4'hF, 3, 0, 16, 0, 16};
        tbl[1] = '{1, 16, 1, 4'hF, 2, 1, 16, 0, 4};
        tbl[2] = '{0, 16, 1, 4'h9, 4, 0, 16, 0, 16};
        tbl[3] = '{0, 20, 0, 4'hF, 3, 0, 16, 1, 16};
        tbl[4] = '{0, 5,  1, 4'hF, 1, 0, 5,  0, 5};
        tbl[5] = '{1, 5,  1, 4'h9, 5, 0, 5,  0, 4};
        tbl[6] = '{0, 1,  1, 4'h9, 2, 1, 1,  0, 1};
        tbl[7] = '{1, 20, 0, 4'h9, 3, 0, 16, 1, 4};
        tbl[8] = '{0, 16, 0, 4'hF, 2, 0, 16, 1, 16};
        tbl[9] = '{0, 15, 1, 4'hF, 1, 0, 15, 0, 15};

        repeat (2) @(negedge clk);
        chk("reset:outs_zero", any_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_frame(tbl[i], $sformatf("vec%0d", i));

        core_lat = 30;
        rdy_pat  = 4'hF;
        stray    = 1'b0;
        drive_frame(0, 8, 1);
        repeat (4) @(negedge clk);
        chk("rst:busy_in_wait", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst:outs_zero", any_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst:idle_after", o_busy, 0);
        run_frame('{0, 8, 1, 4'h9, 2, 0, 8, 0, 8}, "post_rst");

        for (int r = 0; r < 12; r++) begin
            md = 1'($urandom_range(0, 1));
            ln = $urandom_range(1, 22);
            ls = (ln < MAXP) ? 1'b1 : 1'($urandom_range(0, 1));
            rv = model(md, ln, ls);
            rv.pat   = 4'($urandom) | 4'h1;
            rv.lat   = $urandom_range(1, 6);
            rv.stray = 1'($urandom_range(0, 1));
            run_frame(rv, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sobel_frame_scheduler.md
Name: sobel_frame_scheduler

Overview:
Frame-level sequencer in front of the Sobel core (FSM_Module_Sobel) and its two BRAMs. It streams one frame of input pixels into BRAM0 through port 0 and latches the mode. It kicks the core with the en/num_cnt/run interface and waits for core done. It then streams the result out of BRAM1 through port 0 with valid/ready backpressure, and accepts no new frame until readout completes.

Parameters:
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 16, BRAM address width
IMAGE_WIDTH, 100, pixels per line
IMAGE_HEIGHT, 100, lines per frame
MAX_PIXELS, IMAGE_WIDTH*IMAGE_HEIGHT, input pixel cap per frame
RUN_OUT_CNT, (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2), readout length in Sobel mode

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_mode_run  in  1  1=Sobel, 0=move; sampled on the first accepted input pixel
s_valid  in  1  input pixel valid
s_data  in  DATA_WIDTH  input pixel
s_last  in  1  last pixel of frame
s_ready  out  1  input accept
b0_ce0  out  1  BRAM0 port0 enable
b0_we0  out  1  BRAM0 port0 write enable
b0_addr0  out  ADDR_WIDTH  BRAM0 port0 address
b0_d0  out  DATA_WIDTH  BRAM0 port0 write data
o_core_en  out  1  core start pulse (core i_en)
o_core_num_cnt  out  ADDR_WIDTH  frame pixel count (core i_num_cnt)
o_core_run  out  1  core mode (core i_run)
i_core_idle  in  1  core o_idle
i_core_done  in  1  core o_done
b1_ce0  out  1  BRAM1 port0 enable
b1_addr0  out  ADDR_WIDTH  BRAM1 port0 read address
b1_q0  in  DATA_WIDTH  BRAM1 read data, valid 1 cycle after ce0
m_valid  out  1  output pixel valid
m_data  out  DATA_WIDTH  output pixel
m_last  out  1  last output pixel
m_ready  in  1  output accept
o_busy  out  1  state != IDLE
o_err_len  out  1  sticky: frame truncated at MAX_PIXELS; cleared by next frame start

Behaviour:
- Reset: state=IDLE. All outputs 0. Counters and the skid buffer are cleared. Reset mid-frame abandons the frame; BRAM contents are not cleared.
- States: IDLE, LOAD, KICK, WAIT, DRAIN, DONE.
- IDLE:
  - s_ready=1 only when i_core_idle=1.
  - The first handshake (s_valid&&s_ready) writes addr 0, latches i_mode_run into run_q, clears o_err_len and goes to LOAD. If s_last is set on that handshake, go straight to KICK.
- LOAD:
  - s_ready=1.
  - Each handshake drives b0_ce0=b0_we0=1, b0_addr0=wr_cnt, b0_d0=s_data, then wr_cnt+1. No bubbles are inserted.
  - Exit to KICK on a handshake with s_last, or on the handshake where wr_cnt==MAX_PIXELS-1. The latter sets o_err_len=1 if s_last=0. Further input is stalled (s_ready=0) until the next IDLE.
- KICK:
  - One cycle. o_core_en=1. o_core_num_cnt=wr_cnt+1 (total pixels written), held stable until the next KICK. o_core_run=run_q, held.
  - Next state WAIT.
- WAIT: advance to DRAIN on the first cycle with i_core_done=1. A done seen in KICK is ignored.
- DRAIN:
  - out_total = run_q ? RUN_OUT_CNT : o_core_num_cnt.
  - Reads rd_addr 0..out_total-1 with b1_ce0=1, b1_addr0=rd_addr.
  - A 2-entry skid FIFO holds returned data. Issue a read only if (fifo occupancy + reads in flight) < 2.
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_last=1 with the pixel whose output index == out_total-1.
  - With m_ready held 1, throughput is 1 pixel/clk after a 2-cycle initial latency (ce0 -> q -> m_valid).
  - Exit to DONE on the handshake of the m_last pixel.
- DONE: one cycle, then IDLE.
- Counters are ADDR_WIDTH wide. MAX_PIXELS must be <= 2^ADDR_WIDTH; out_total==0 is not supported.
- m_valid, once asserted, holds with m_data stable until m_ready.
- s_ready=0 in KICK, WAIT, DRAIN and DONE.

Test Plan:
- W=H=4, mode=0: 16 pixels 0..15 with s_last on 15 -> BRAM0 addr0..15 written; one o_core_en pulse with num_cnt=16, run=0; after core done, 16 m_valid beats reading BRAM1 addr 0..15, m_last on beat 16.
- W=H=4, mode=1, m_ready=1: readout is exactly 4 beats (RUN_OUT_CNT), m_last on beat 4, first m_valid 2 cycles after entering DRAIN.
- Backpressure: m_ready toggling 1,0,0,1 repeatedly -> no data lost or duplicated, m_data stable while stalled, b1_ce0 never issues a third outstanding read.
- Truncation: W=H=4, 20 pixels with no s_last -> 16 written, s_ready drops after pixel 16, o_err_len=1, num_cnt=16; o_err_len clears when the next frame starts.
- Early s_last on pixel 5 -> num_cnt=5; move-mode readout is 5 beats.
- Async reset asserted in WAIT -> all outputs 0 immediately; a subsequent frame with i_core_idle=1 completes normally.
